// File: rtl/gpr_wb_arb.sv
// -----------------------------------------------------------------------------
// gpr_wb_arb
// Write-port arbiter and pending-write scoreboard for the single-write-port
// GPR file. NUM_SRC writeback requesters share one registered GPR write port
// under round-robin priority; the busy mask tells the issue stage which
// registers still have a write outstanding.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   src_val   per-requester write pending (bit i)
//   src_rdy   one-hot grant, combinational; transfer on src_val[i] & src_rdy[i]
//   src_adr   packed target addresses, slice i = [i*ADR_W +: ADR_W]
//   src_dat   packed write data,       slice i = [i*DAT_W +: DAT_W]
//   wb_hold   suppress all grants this cycle
//   iss_val   issue stage reserves iss_adr this cycle
//   iss_adr   register being reserved
//   busy      pending-write mask (registered), bit r = write to r outstanding
//   wr_en_0   GPR write enable  (registered)
//   wr_adr_0  GPR write address (registered)
//   wr_dat_0  GPR write data    (registered)
// -----------------------------------------------------------------------------
module gpr_wb_arb #(
  parameter int NUM_SRC = 3,
  parameter int ADR_W   = 5,
  parameter int DAT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_val,
  output logic [NUM_SRC-1:0]       src_rdy,
  input  logic [NUM_SRC*ADR_W-1:0] src_adr,
  input  logic [NUM_SRC*DAT_W-1:0] src_dat,
  input  logic                     wb_hold,
  input  logic                     iss_val,
  input  logic [ADR_W-1:0]         iss_adr,
  output logic [(1<<ADR_W)-1:0]    busy,
  output logic                     wr_en_0,
  output logic [ADR_W-1:0]         wr_adr_0,
  output logic [DAT_W-1:0]         wr_dat_0
);

  localparam int NREG  = 1 << ADR_W;
  // NUM_SRC is limited to 2..4, so a 2-bit pointer always suffices.
  localparam int PTR_W = 2;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             wr_en_q, wr_en_d;
  logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
  logic [DAT_W-1:0] wr_dat_q, wr_dat_d;
  logic [NREG-1:0]  busy_q, busy_d;

  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] gnt_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               gnt_any_s;
  logic [NREG-1:0]    set_s;
  logic [NREG-1:0]    clr_s;

  function automatic logic [NREG-1:0] onehot_adr(input logic [ADR_W-1:0] adr);
    logic [NREG-1:0] r;
    r      = '0;
    r[adr] = 1'b1;
    return r;
  endfunction

  // Requests that may compete this cycle; grants are forced off in reset and on hold.
  assign req_s = (rst_n && !wb_hold) ? src_val : '0;

  // Round-robin search starting at ptr_q; first requester found wins.
  always_comb begin
    logic hit_s;
    gnt_s     = '0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        // Source i is the k-th candidate when (ptr + k) mod NUM_SRC == i.
        hit_s     = !gnt_any_s && req_s[i] && (i == ((int'(ptr_q) + k) % NUM_SRC));
        gnt_s[i]  = gnt_s[i] | hit_s;
        gnt_idx_s = hit_s ? PTR_W'(i) : gnt_idx_s;
        gnt_any_s = gnt_any_s | hit_s;
      end
    end
  end

  assign src_rdy = gnt_s;

  // Scoreboard update terms: reservation from issue, release by the commit in flight.
  assign set_s = iss_val ? onehot_adr(iss_adr)  : '0;
  assign clr_s = wr_en_q ? onehot_adr(wr_adr_q) : '0;

  // Next-state: commit capture, pointer advance and busy mask.
  always_comb begin
    wr_en_d  = gnt_any_s;
    wr_adr_d = wr_adr_q;
    wr_dat_d = wr_dat_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      wr_adr_d = gnt_s[i] ? src_adr[i*ADR_W +: ADR_W] : wr_adr_d;
      wr_dat_d = gnt_s[i] ? src_dat[i*DAT_W +: DAT_W] : wr_dat_d;
    end
    ptr_d = gnt_any_s ? ((gnt_idx_s == PTR_W'(NUM_SRC - 1)) ? PTR_W'(0) : gnt_idx_s + PTR_W'(1))
                      : ptr_q;
    // Set is applied after clear so an issue to the register being written keeps it busy.
    busy_d = (busy_q & ~clr_s) | set_s;
  end

  // State registers; asynchronous reset drops any in-flight commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
      busy_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wr_en_q  <= wr_en_d;
      wr_adr_q <= wr_adr_d;
      wr_dat_q <= wr_dat_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_en_0  = wr_en_q;
  assign wr_adr_0 = wr_adr_q;
  assign wr_dat_0 = wr_dat_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_gpr_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_gpr_wb_arb
// Directed bench for gpr_wb_arb (NUM_SRC=3, ADR_W=5, DAT_W=32). Each step
// states the grant it expects; the expected commit and busy mask are pushed
// to a scoreboard queue and popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_gpr_wb_arb;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic           clk;
  logic           rst_n;
  logic [NS-1:0]  src_val;
  logic [NS-1:0]  src_rdy;
  logic [NS*AW-1:0] src_adr;
  logic [NS*DW-1:0] src_dat;
  logic           wb_hold;
  logic           iss_val;
  logic [AW-1:0]  iss_adr;
  logic [31:0]    busy;
  logic           wr_en_0;
  logic [AW-1:0]  wr_adr_0;
  logic [DW-1:0]  wr_dat_0;

  gpr_wb_arb #(.NUM_SRC(NS), .ADR_W(AW), .DAT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .src_val(src_val), .src_rdy(src_rdy),
    .src_adr(src_adr), .src_dat(src_dat), .wb_hold(wb_hold),
    .iss_val(iss_val), .iss_adr(iss_adr), .busy(busy),
    .wr_en_0(wr_en_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [31:0]   bsy;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Per-source stimulus values and the bench's copy of the committed state.
  logic [AW-1:0] s_adr [NS];
  logic [DW-1:0] s_dat [NS];
  logic          m_en;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [31:0]   m_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_srcs();
    for (int i = 0; i < NS; i++) begin
      src_adr[i*AW +: AW] = s_adr[i];
      src_dat[i*DW +: DW] = s_dat[i];
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_adr = '0; m_dat = '0; m_busy = '0;
    sb.delete();
  endtask

  // One clock: check the stated grant, push the expected commit, then pop and compare after the edge.
  task automatic step(input string tag, input int want);
    exp_t e;
    logic [NS-1:0] g;
    logic [31:0] clr, set;
    pack_srcs();
    #1;
    g = '0;
    if (want >= 0) g = 3'b001 << want;
    chk({tag, ".src_rdy"}, 64'(src_rdy), 64'(g));
    clr = 32'd0;
    if (m_en) clr = 32'd1 << m_adr;
    set = 32'd0;
    if (iss_val) set = 32'd1 << iss_adr;
    e.en  = (want >= 0);
    e.adr = (want >= 0) ? s_adr[want] : m_adr;
    e.dat = (want >= 0) ? s_dat[want] : m_dat;
    e.bsy = (m_busy & ~clr) | set;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".wr_en_0"},  64'(wr_en_0),  64'(e.en));
    chk({tag, ".wr_adr_0"}, 64'(wr_adr_0), 64'(e.adr));
    chk({tag, ".wr_dat_0"}, 64'(wr_dat_0), 64'(e.dat));
    chk({tag, ".busy"},     64'(busy),     64'(e.bsy));
    m_en = e.en; m_adr = e.adr; m_dat = e.dat; m_busy = e.bsy;
  endtask

  initial begin
    s_adr[0] = 5'd3;  s_dat[0] = 32'hA000_0003;
    s_adr[1] = 5'd7;  s_dat[1] = 32'hB100_0007;
    s_adr[2] = 5'd0;  s_dat[2] = 32'hC2C2_0000;
    rst_n = 1'b0; src_val = 3'b111; wb_hold = 1'b0;
    iss_val = 1'b0; iss_adr = 5'd0;
    src_adr = '0; src_dat = '0;
    pack_srcs();
    model_reset();

    // 1: reset with all requesters valid
    #2;
    chk("rst.src_rdy", 64'(src_rdy), 64'd0);
    chk("rst.wr_en_0", 64'(wr_en_0), 64'd0);
    chk("rst.busy",    64'(busy),    64'd0);
    @(posedge clk); #1;
    chk("rst.wr_adr_0", 64'(wr_adr_0), 64'd0);
    chk("rst.wr_dat_0", 64'(wr_dat_0), 64'd0);
    rst_n = 1'b1;

    // 2: round robin with all valid
    src_val = 3'b111;
    step("rr0", 0); step("rr1", 1); step("rr2", 2);
    step("rr3", 0); step("rr4", 1); step("rr5", 2);

    // 3: pointer skip and wrap
    src_val = 3'b010; step("ptr_to2", 1);
    src_val = 3'b011; step("skip", 0);
    src_val = 3'b100; step("wrap", 2);
    src_val = 3'b011; step("after_wrap", 0);

    // 4: hold blocks grants and freezes pointer (ptr=1)
    src_val = 3'b010; wb_hold = 1'b1;
    step("hold0", -1); step("hold1", -1); step("hold2", -1);
    wb_hold = 1'b0; step("unhold", 1);
    src_val = 3'b000; step("idle", -1);

    // 5: scoreboard set/clear collision on r5 (ptr=2)
    s_adr[0] = 5'd5; s_dat[0] = 32'h5555_0001;
    iss_val = 1'b1; iss_adr = 5'd5; step("iss5", -1);
    chk("iss5.busy5", 64'(busy[5]), 64'd1);
    iss_val = 1'b0; src_val = 3'b001; step("gnt5a", 0);
    src_val = 3'b000; iss_val = 1'b1; iss_adr = 5'd5; step("collide", -1);
    chk("collide.busy5", 64'(busy[5]), 64'd1);
    iss_val = 1'b0; s_dat[0] = 32'h5555_0002; src_val = 3'b001; step("gnt5b", 0);
    src_val = 3'b000; iss_val = 1'b1; iss_adr = 5'd9; step("clear5", -1);
    chk("clear5.busy5", 64'(busy[5]), 64'd0);
    chk("clear5.busy9", 64'(busy[9]), 64'd1);
    iss_val = 1'b0;

    // 6: asynchronous reset during a grant (ptr=1, src 0 alone -> grant 0)
    src_val = 3'b001; pack_srcs();
    #2;
    chk("arst.pre_rdy", 64'(src_rdy), 64'b001);
    rst_n = 1'b0;
    #1;
    chk("arst.src_rdy",  64'(src_rdy),  64'd0);
    chk("arst.wr_en_0",  64'(wr_en_0),  64'd0);
    chk("arst.wr_adr_0", 64'(wr_adr_0), 64'd0);
    chk("arst.busy",     64'(busy),     64'd0);
    @(posedge clk); #1;
    chk("arst.edge_wr_en", 64'(wr_en_0),  64'd0);
    chk("arst.edge_dat",   64'(wr_dat_0), 64'd0);
    model_reset();
    rst_n = 1'b1;
    src_val = 3'b011; step("post_rst", 0);
    src_val = 3'b000; step("post_rst_idle", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
